// File: rtl/ifetch_if.sv
// Fetch-stage bundle: pc feedback, instruction memory bus and decode handshake.
// With IFETCH_MISALIGN_EN defined the bundle also carries instr_misalign.
interface ifetch_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            pc_en;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  logic            redirect;
  logic [XLEN-1:0] redirect_target;

  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
`ifdef IFETCH_MISALIGN_EN
  logic            instr_misalign;
`endif

  // master: the fetch stage; slave: pc register, memory and decode around it
  modport master (
    input  pc,
    output pc_next, pc_en,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_target,
    output instr_valid, instr, instr_pc,
    input  instr_ready
`ifdef IFETCH_MISALIGN_EN
    , output instr_misalign
`endif
  );

  modport slave (
    output pc,
    input  pc_next, pc_en,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_target,
    input  instr_valid, instr, instr_pc,
    output instr_ready
`ifdef IFETCH_MISALIGN_EN
    , input instr_misalign
`endif
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: one outstanding imem read, FETCH/WAIT/HOLD sequencing.
// Optional IFETCH_MISALIGN_EN flags misaligned pc instead of issuing a fetch.
module ifetch #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input logic     clk,
  input logic     rst,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;

`ifdef IFETCH_MISALIGN_EN
  logic            misalign_q, misalign_d;
  logic            pc_misaligned;

  assign pc_misaligned      = |bus.pc[1:0];
  assign bus.imem_req       = (state_q == FETCH) && !pc_misaligned && !rst;
  assign bus.instr_misalign = misalign_q;
`else
  assign bus.imem_req       = (state_q == FETCH) && !rst;
`endif

  assign bus.imem_addr   = {bus.pc[XLEN-1:2], 2'b00};
  assign bus.pc_en       = bus.redirect || ((state_q == HOLD) && bus.instr_ready);
  assign bus.pc_next     = bus.redirect ? bus.redirect_target : bus.pc + XLEN'(4);
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef IFETCH_MISALIGN_EN
    misalign_d    = misalign_q;
`endif

    case (state_q)
      FETCH: begin
`ifdef IFETCH_MISALIGN_EN
        if (pc_misaligned) begin
          // No request goes out; a redirect simply keeps us in FETCH on the new pc.
          if (!bus.redirect) begin
            state_d       = HOLD;
            instr_d       = RESET_INSTR;
            instr_pc_d    = bus.pc;
            instr_valid_d = 1'b1;
            misalign_d    = 1'b1;
          end
        end else
`endif
        if (bus.imem_gnt) begin
          state_d    = WAIT;
          fetch_pc_d = bus.pc;
          // A redirect in the grant cycle makes the response stale before it lands.
          discard_d  = bus.redirect;
        end
      end

      WAIT: begin
        if (bus.imem_rvalid) begin
          if (discard_q || bus.redirect) begin
            state_d   = FETCH;
            discard_d = 1'b0;
          end else begin
            state_d       = HOLD;
            instr_d       = bus.imem_rdata;
            instr_pc_d    = fetch_pc_q;
            instr_valid_d = 1'b1;
          end
        end else if (bus.redirect) begin
          discard_d = 1'b1;
        end
      end

      HOLD: begin
        if (bus.redirect || bus.instr_ready) begin
          state_d       = FETCH;
          instr_valid_d = 1'b0;
`ifdef IFETCH_MISALIGN_EN
          misalign_d    = 1'b0;
`endif
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      discard_q     <= 1'b0;
      fetch_pc_q    <= '0;
      instr_q       <= RESET_INSTR;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
`ifdef IFETCH_MISALIGN_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
`ifdef IFETCH_MISALIGN_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: the bench plays pc register, memory and decode,
// and a scoreboard queue holds the instruction/pc each accepted fetch must deliver.
module tb_ifetch;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_if #(.XLEN(XLEN)) bus ();

  ifetch #(.XLEN(XLEN), .RESET_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.redirect = 1'b0; bus.redirect_target = '0; bus.instr_ready = 1'b0;
  endtask

  // Drive one fetch at pc p until the DUT sits in HOLD, then pop and compare.
  task automatic fetch_to_hold(input logic [31:0] p, input int gd, input int rd, input logic [31:0] data);
    exp_t e;
    logic [31:0] a;
    e.instr = data; e.pc = p; a = {p[31:2], 2'b00};
    bus.pc = p;
    sb.push_back(e);
    for (int i = 0; i < gd; i++) begin
      #1;
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL req_before_gnt pc=%h got=%b exp=1", p, bus.imem_req); end
      tick();
    end
    bus.imem_gnt = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL req_gnt pc=%h got=%b exp=1", p, bus.imem_req); end
    checks++; if (bus.imem_addr !== a) begin errors++; $display("FAIL imem_addr got=%h exp=%h", bus.imem_addr, a); end
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL pc_en_fetch got=%b exp=0", bus.pc_en); end
    tick();
    bus.imem_gnt = 1'b0;
    for (int i = 0; i < rd; i++) begin
      #1;
      checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL wait_idle got req=%b valid=%b exp req=0 valid=0", bus.imem_req, bus.instr_valid); end
      tick();
    end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = data;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL valid_early got=%b exp=0", bus.instr_valid); end
    tick();
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    last_exp = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b exp=1", bus.instr_valid); end
    checks++; if (bus.instr !== last_exp.instr) begin errors++; $display("FAIL hold_instr got=%h exp=%h", bus.instr, last_exp.instr); end
    checks++; if (bus.instr_pc !== last_exp.pc) begin errors++; $display("FAIL hold_instr_pc got=%h exp=%h", bus.instr_pc, last_exp.pc); end
  endtask

  // Stall decode for 'stall' cycles, then accept; the bench then loads pc itself.
  task automatic release_hold(input logic [31:0] p, input int stall);
    logic [31:0] nxt;
    nxt = p + 32'd4;
    for (int i = 0; i < stall; i++) begin
      bus.instr_ready = 1'b0;
      #1;
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== last_exp.instr || bus.instr_pc !== last_exp.pc) begin errors++; $display("FAIL stall_stable got v=%b i=%h p=%h exp v=1 i=%h p=%h", bus.instr_valid, bus.instr, bus.instr_pc, last_exp.instr, last_exp.pc); end
      checks++; if (bus.pc_en !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_quiet got pc_en=%b req=%b exp 0 0", bus.pc_en, bus.imem_req); end
      tick();
    end
    bus.instr_ready = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL accept_pc_en got=%b exp=1", bus.pc_en); end
    checks++; if (bus.pc_next !== nxt) begin errors++; $display("FAIL accept_pc_next got=%h exp=%h", bus.pc_next, nxt); end
    tick();
    bus.instr_ready = 1'b0;
    bus.pc = nxt;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.pc_en !== 1'b0) begin errors++; $display("FAIL after_accept got valid=%b pc_en=%b exp 0 0", bus.instr_valid, bus.pc_en); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.pc = 32'h0;
    tick(); tick();
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.instr !== NOP) begin errors++; $display("FAIL rst_instr got=%h exp=%h", bus.instr, NOP); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got=%h exp=0", bus.instr_pc); end
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc_en got=%b exp=0", bus.pc_en); end
`ifdef IFETCH_MISALIGN_EN
    checks++; if (bus.instr_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%b exp=0", bus.instr_misalign); end
`endif
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_req got=%b exp=1", bus.imem_req); end
    tick();
  endtask

  task automatic test_basic();
    fetch_to_hold(32'h0, 0, 0, 32'h0050_0093);
    release_hold(32'h0, 0);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_req got req=%b addr=%h exp 1 00000004", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_stall();
    fetch_to_hold(32'h4, 0, 0, 32'h0010_8113);
    release_hold(32'h4, 5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    p = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      fetch_to_hold(p, i % 2, (i + 1) % 3, $urandom);
      release_hold(p, 0);
      p = p + 32'd4;
    end
  endtask

  task automatic test_redirect_fetch();
    bus.pc = 32'h100;
    bus.redirect = 1'b1; bus.redirect_target = 32'h300;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.pc_next !== 32'h300) begin errors++; $display("FAIL rd_fetch_nognt got pc_en=%b next=%h exp 1 00000300", bus.pc_en, bus.pc_next); end
    tick();
    bus.redirect = 1'b0; bus.pc = 32'h300;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin errors++; $display("FAIL rd_fetch_newaddr got req=%b addr=%h exp 1 00000300", bus.imem_req, bus.imem_addr); end
    // redirect in the grant cycle: the response must be dropped
    bus.imem_gnt = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h400;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.pc_next !== 32'h400) begin errors++; $display("FAIL rd_fetch_gnt got pc_en=%b next=%h exp 1 00000400", bus.pc_en, bus.pc_next); end
    tick();
    bus.imem_gnt = 1'b0; bus.redirect = 1'b0; bus.pc = 32'h400;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0001;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400) begin errors++; $display("FAIL rd_fetch_drop got valid=%b req=%b addr=%h exp 0 1 00000400", bus.instr_valid, bus.imem_req, bus.imem_addr); end
    // redirect together with rvalid in WAIT
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0002;
    bus.redirect = 1'b1; bus.redirect_target = 32'h500;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.pc_next !== 32'h500) begin errors++; $display("FAIL rd_wait_rvalid got pc_en=%b next=%h exp 1 00000500", bus.pc_en, bus.pc_next); end
    tick();
    clear_inputs(); bus.pc = 32'h500;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h500) begin errors++; $display("FAIL rd_wait_rvalid_drop got valid=%b req=%b addr=%h exp 0 1 00000500", bus.instr_valid, bus.imem_req, bus.imem_addr); end
    fetch_to_hold(32'h500, 0, 1, 32'h0000_0517);
    release_hold(32'h500, 1);
  endtask

  task automatic test_redirect_wait();
    bus.pc = 32'h10; bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    bus.redirect = 1'b1; bus.redirect_target = 32'h200;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.pc_next !== 32'h200) begin errors++; $display("FAIL rd_wait got pc_en=%b next=%h exp 1 00000200", bus.pc_en, bus.pc_next); end
    tick();
    bus.redirect = 1'b0; bus.pc = 32'h200;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rd_wait_still_wait got req=%b exp=0", bus.imem_req); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0003;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rd_wait_stale got valid=%b exp=0", bus.instr_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rd_wait_newaddr got req=%b addr=%h exp 1 00000200", bus.imem_req, bus.imem_addr); end
    fetch_to_hold(32'h200, 0, 0, 32'h0020_0213);
    release_hold(32'h200, 0);
  endtask

  task automatic test_redirect_hold();
    fetch_to_hold(32'h40, 0, 0, 32'h0030_0313);
    bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h80;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.pc_next !== 32'h80) begin errors++; $display("FAIL rd_hold got pc_en=%b next=%h exp 1 00000080", bus.pc_en, bus.pc_next); end
    tick();
    clear_inputs(); bus.pc = 32'h80;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.pc_en !== 1'b0) begin errors++; $display("FAIL rd_hold_after got valid=%b pc_en=%b exp 0 0", bus.instr_valid, bus.pc_en); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin errors++; $display("FAIL rd_hold_newaddr got req=%b addr=%h exp 1 00000080", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_wrap();
    fetch_to_hold(32'hFFFF_FFFC, 3, 2, 32'h0040_0413);
    bus.instr_ready = 1'b1;
    #1;
    checks++; if (bus.pc_next !== 32'h0) begin errors++; $display("FAIL wrap_pc_next got=%h exp=00000000", bus.pc_next); end
    tick();
    bus.instr_ready = 1'b0; bus.pc = 32'h0;
  endtask

  task automatic test_reset_mid();
    fetch_to_hold(32'h80, 0, 0, 32'h0050_0513);
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr !== NOP || bus.instr_pc !== 32'h0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_mid got v=%b i=%h p=%h req=%b exp 0 %h 0 0", bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req, NOP); end
    tick();
    rst = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0004;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_fetch got req=%b exp=1", bus.imem_req); end
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale got valid=%b exp=0", bus.instr_valid); end
  endtask

`ifdef IFETCH_MISALIGN_EN
  task automatic test_misalign();
    bus.pc = 32'h102;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mis_req got=%b exp=0", bus.imem_req); end
    tick();
    #1;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got valid=%b mis=%b exp 1 1", bus.instr_valid, bus.instr_misalign); end
    checks++; if (bus.instr !== NOP || bus.instr_pc !== 32'h102 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL mis_data got i=%h p=%h req=%b exp %h 00000102 0", bus.instr, bus.instr_pc, bus.imem_req, NOP); end
    bus.instr_ready = 1'b1;
    #1;
    checks++; if (bus.pc_en !== 1'b1 || bus.pc_next !== 32'h106) begin errors++; $display("FAIL mis_accept got pc_en=%b next=%h exp 1 00000106", bus.pc_en, bus.pc_next); end
    tick();
    bus.instr_ready = 1'b0; bus.pc = 32'h106;
    #1;
    checks++; if (bus.instr_misalign !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mis_clear got mis=%b valid=%b exp 0 0", bus.instr_misalign, bus.instr_valid); end
    tick();
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr_misalign !== 1'b0 || bus.instr !== NOP || bus.instr_pc !== 32'h0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL mis_rst got v=%b m=%b i=%h p=%h req=%b exp 0 0 %h 0 0", bus.instr_valid, bus.instr_misalign, bus.instr, bus.instr_pc, bus.imem_req, NOP); end
    bus.pc = 32'h108;
    tick();
    rst = 1'b0;
  endtask
`else
  task automatic test_misalign();
    fetch_to_hold(32'h102, 0, 0, 32'h0060_0613);
    release_hold(32'h102, 0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    bus.pc = '0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_redirect_fetch();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    test_misalign();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
